// File: rtl/pipe_hazard_ctrl_pkg.sv
// hazard_pkg: FSM state type, pipeline constants and watchdog width helper for pipe_hazard_ctrl.
package hazard_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [1:0] PC_SEL_SEQ = 2'd0;
    localparam logic [4:0] REG_X0     = 5'd0;

    function automatic int cnt_w(input int t);
        return (t <= 1) ? 1 : $clog2(t + 1);
    endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline hazard inputs and stage control outputs; master is the hazard controller.
interface pipe_hazard_ctrl_if;
    logic       memread_id_ex;
    logic [4:0] rd_id_ex;
    logic [4:0] rs1_if_id;
    logic [4:0] rs2_if_id;
    logic       use_rs1_if_id;
    logic       use_rs2_if_id;
    logic       branch_ex_mem;
    logic       z_flag_ex_mem;
    logic [1:0] pc_sel_ex_mem;
    logic       memread_ex_mem;
    logic       memwrite_ex_mem;
    logic       dmem_ack;
    logic       dmem_req;
    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_flush;
    logic       ex_mem_en;
    logic       ex_mem_flush;
    logic       mem_wb_bubble;
    logic       redirect;
    logic       dmem_err;

    modport master (
        input  memread_id_ex, rd_id_ex, rs1_if_id, rs2_if_id, use_rs1_if_id, use_rs2_if_id,
               branch_ex_mem, z_flag_ex_mem, pc_sel_ex_mem, memread_ex_mem, memwrite_ex_mem, dmem_ack,
        output dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
               mem_wb_bubble, redirect, dmem_err
    );

    modport slave (
        output memread_id_ex, rd_id_ex, rs1_if_id, rs2_if_id, use_rs1_if_id, use_rs2_if_id,
               branch_ex_mem, z_flag_ex_mem, pc_sel_ex_mem, memread_ex_mem, memwrite_ex_mem, dmem_ack,
        input  dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
               mem_wb_bubble, redirect, dmem_err
    );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use.sv
// load_use_detect: combinational load-use compare between the load in EX and the operands in ID.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic       memread,
    input  logic [4:0] rd,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       use_rs1,
    input  logic       use_rs2,
    output logic       hazard
);
    assign hazard = memread && rd != REG_X0 && ((use_rs1 && rd == rs1) || (use_rs2 && rd == rs2));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush scheduler and data-memory handshake watchdog for the 5-stage core.
// Optional HAZARD_PERF_EN adds load-use, flush and frozen-cycle performance counters.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic clk,
    input  logic reset,
    pipe_hazard_ctrl_if.master hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_lu,
    output logic [CNT_W-1:0] perf_flush,
    output logic [CNT_W-1:0] perf_mem_wait
`endif
);
    localparam int CW = cnt_w(TIMEOUT);

    state_t state;
    logic [CW-1:0] cnt;
    logic lu, take, mem_op, freeze, flush_x, lu_stall;

    load_use_detect u_lu (
        .memread (hz.memread_id_ex),
        .rd      (hz.rd_id_ex),
        .rs1     (hz.rs1_if_id),
        .rs2     (hz.rs2_if_id),
        .use_rs1 (hz.use_rs1_if_id),
        .use_rs2 (hz.use_rs2_if_id),
        .hazard  (lu)
    );

    assign mem_op = hz.memread_ex_mem || hz.memwrite_ex_mem;
    assign take   = (hz.branch_ex_mem && hz.z_flag_ex_mem) || hz.pc_sel_ex_mem != PC_SEL_SEQ;

    // Ack releases the freeze in the same cycle, so both RUN and MEM_WAIT stall only while ack is low.
    always_comb begin
        freeze   = !reset && (state == ERR || (state == MEM_WAIT && !hz.dmem_ack) ||
                              (state == RUN && mem_op && !hz.dmem_ack));
        flush_x  = !reset && !freeze && take;
        lu_stall = !reset && !freeze && !take && lu;
        hz.dmem_req      = !reset && mem_op && state != ERR;
        hz.pc_en         = !freeze && !lu_stall;
        hz.if_id_en      = !freeze && !lu_stall;
        hz.id_ex_en      = !freeze;
        hz.ex_mem_en     = !freeze;
        hz.if_id_flush   = flush_x;
        hz.id_ex_flush   = flush_x || lu_stall;
        hz.ex_mem_flush  = flush_x;
        hz.redirect      = flush_x;
        hz.mem_wb_bubble = freeze;
        hz.dmem_err      = !reset && state == ERR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: if (mem_op && !hz.dmem_ack) begin
                    state <= MEM_WAIT;
                    cnt   <= CW'(1);
                end
                MEM_WAIT: if (hz.dmem_ack) begin
                    state <= RUN;
                    cnt   <= '0;
                end else if (TIMEOUT != 0 && cnt == CW'(TIMEOUT)) begin
                    state <= ERR;
                end else if (cnt != '1) begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= ERR;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_lu <= '0;
            perf_flush    <= '0;
            perf_mem_wait <= '0;
        end else begin
            perf_stall_lu <= perf_stall_lu + CNT_W'(lu_stall);
            perf_flush    <= perf_flush + CNT_W'(flush_x);
            perf_mem_wait <= perf_mem_wait + CNT_W'(freeze);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of pipe_hazard_ctrl with TIMEOUT = 4.
// Output vector order: req pc_en if_id_en if_id_flush id_ex_en id_ex_flush ex_mem_en ex_mem_flush bubble redirect err.
module tb_pipe_hazard_ctrl;
    localparam logic [10:0] NORM   = 11'b0_1_1_0_1_0_1_0_0_0_0;
    localparam logic [10:0] LU     = 11'b0_0_0_0_1_1_1_0_0_0_0;
    localparam logic [10:0] FLUSH  = 11'b0_1_1_1_1_1_1_1_0_1_0;
    localparam logic [10:0] FREEZE = 11'b1_0_0_0_0_0_0_0_1_0_0;
    localparam logic [10:0] HIT    = 11'b1_1_1_0_1_0_1_0_0_0_0;
    localparam logic [10:0] HITFL  = 11'b1_1_1_1_1_1_1_1_0_1_0;
    localparam logic [10:0] ERRV   = 11'b0_0_0_0_0_0_0_0_1_0_1;

    logic clk = 0;
    logic reset = 1;
    int n_tests = 0;
    int n_fail = 0;
    logic [10:0] obs;

    pipe_hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_lu, perf_flush, perf_mem_wait;
    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .hz(hz.master),
        .perf_stall_lu(perf_stall_lu), .perf_flush(perf_flush), .perf_mem_wait(perf_mem_wait)
    );
`else
    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (.clk(clk), .reset(reset), .hz(hz.master));
`endif

    always #5 clk = ~clk;

    assign obs = {hz.dmem_req, hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en, hz.id_ex_flush,
                  hz.ex_mem_en, hz.ex_mem_flush, hz.mem_wb_bubble, hz.redirect, hz.dmem_err};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic idle();
        hz.memread_id_ex = 0; hz.rd_id_ex = 0; hz.rs1_if_id = 0; hz.rs2_if_id = 0;
        hz.use_rs1_if_id = 0; hz.use_rs2_if_id = 0; hz.branch_ex_mem = 0; hz.z_flag_ex_mem = 0;
        hz.pc_sel_ex_mem = 0; hz.memread_ex_mem = 0; hz.memwrite_ex_mem = 0; hz.dmem_ack = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs2);
        hz.memread_id_ex = 1; hz.rd_id_ex = rd; hz.rs2_if_id = rs2; hz.use_rs2_if_id = 1;
    endtask

    task automatic cyc(input string tag, input logic [10:0] exp);
        #1 check(tag, {21'd0, obs}, {21'd0, exp});
        @(negedge clk);
    endtask

    initial begin
        idle();
        hz.memread_ex_mem = 1; hz.branch_ex_mem = 1; hz.z_flag_ex_mem = 1; set_lu(5'd3, 5'd3);
        cyc("reset", NORM);
        idle();
        reset = 0;
        cyc("run_idle", NORM);
        set_lu(5'd5, 5'd5);              cyc("lu_rs2", LU);
        idle();                          cyc("lu_release", NORM);
        set_lu(5'd0, 5'd0);              cyc("lu_x0", NORM);
        idle(); hz.memread_id_ex = 1; hz.rd_id_ex = 7; hz.rs1_if_id = 7; hz.use_rs1_if_id = 1;
        cyc("lu_rs1", LU);
        hz.use_rs1_if_id = 0;            cyc("lu_rs1_unused", NORM);
        idle(); hz.branch_ex_mem = 1; hz.z_flag_ex_mem = 1; cyc("br_taken", FLUSH);
        hz.z_flag_ex_mem = 0;            cyc("br_not_taken", NORM);
        idle(); hz.pc_sel_ex_mem = 2'b10; cyc("jump", FLUSH);
        set_lu(5'd5, 5'd5);              cyc("jump_and_lu", FLUSH);
        idle(); hz.memwrite_ex_mem = 1; hz.dmem_ack = 1; cyc("store_hit", HIT);
        idle();                          cyc("after_hit", NORM);
        hz.memread_ex_mem = 1;           cyc("miss_0", FREEZE);
                                         cyc("wait_1", FREEZE);
                                         cyc("wait_2", FREEZE);
        hz.dmem_ack = 1;                 cyc("ack", HIT);
        idle();                          cyc("back_run", NORM);
        hz.memread_ex_mem = 1; hz.branch_ex_mem = 1; hz.z_flag_ex_mem = 1;
        cyc("br_miss", FREEZE);
        cyc("br_wait", FREEZE);
        hz.dmem_ack = 1;                 cyc("br_ack", HITFL);
        idle();                          cyc("br_after", NORM);
        hz.memread_ex_mem = 1;           cyc("to_miss", FREEZE);
        for (int i = 1; i <= 4; i++)     cyc($sformatf("to_wait_%0d", i), FREEZE);
                                         cyc("to_err", ERRV);
        hz.dmem_ack = 1;                 cyc("err_sticky", ERRV);
        reset = 1;                       cyc("err_reset", NORM);
        idle(); reset = 0;               cyc("err_cleared", NORM);
        hz.memread_ex_mem = 1;           cyc("mid_miss", FREEZE);
                                         cyc("mid_wait", FREEZE);
        reset = 1; #1 check("mid_reset", {21'd0, obs}, {21'd0, NORM});
        @(negedge clk);
        reset = 0; hz.memread_ex_mem = 0; cyc("mid_cleared", NORM);
        reset = 1; @(negedge clk); reset = 0;
        set_lu(5'd9, 5'd9);              cyc("p_lu1", LU);
                                         cyc("p_lu2", LU);
        idle(); hz.pc_sel_ex_mem = 2'b01; cyc("p_flush", FLUSH);
        idle(); hz.memread_ex_mem = 1;   cyc("p_miss", FREEZE);
                                         cyc("p_wait1", FREEZE);
                                         cyc("p_wait2", FREEZE);
        hz.dmem_ack = 1;                 cyc("p_ack", HIT);
        idle();
`ifdef HAZARD_PERF_EN
        #1;
        check("perf_stall_lu", perf_stall_lu, 32'd2);
        check("perf_flush", perf_flush, 32'd1);
        check("perf_mem_wait", perf_mem_wait, 32'd3);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipelined RISC-V core. Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves three hazards in fixed priority: data-memory wait, taken branch/jump resolved in MEM, and load-use. Also owns the data-memory request/acknowledge handshake, with a watchdog timeout.

Parameters:
TIMEOUT, 16, max cycles in MEM_WAIT before error; 0 disables the watchdog
CNT_W, 32, width of performance counters (used only with HAZARD_PERF_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
memread_id_ex  in  1  instruction in EX is a load
rd_id_ex  in  5  destination register of the instruction in EX
rs1_if_id  in  5  rs1 of the instruction in ID
rs2_if_id  in  5  rs2 of the instruction in ID
use_rs1_if_id  in  1  ID instruction reads rs1
use_rs2_if_id  in  1  ID instruction reads rs2
branch_ex_mem  in  1  branch in MEM
z_flag_ex_mem  in  1  branch condition true
pc_sel_ex_mem  in  2  nonzero = jal/jalr redirect in MEM
memread_ex_mem  in  1  load in MEM
memwrite_ex_mem  in  1  store in MEM
dmem_ack  in  1  data memory completes access this cycle
dmem_req  out  1  data memory access request
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID clear to NOP
id_ex_en  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX clear to bubble
ex_mem_en  out  1  EX/MEM load enable
ex_mem_flush  out  1  EX/MEM clear to bubble
mem_wb_bubble  out  1  MEM/WB loads bubble (regwrite=0)
redirect  out  1  PC mux takes the branch/jump target
dmem_err  out  1  sticky watchdog error

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. Reset enters RUN; wait counter = 0; dmem_err = 0.
- Outputs are a combinational decode of the current state and inputs.
- Default in RUN: all enables = 1; all flushes, mem_wb_bubble and redirect = 0.
- dmem_req = (memread_ex_mem | memwrite_ex_mem) & (state != ERR).
- During reset, all outputs are 0 except the four enables, which are 1.
- Access hit in RUN: dmem_req & dmem_ack in the same cycle. Zero-wait; no stall.
- Access miss in RUN: dmem_req & !dmem_ack.
  - That cycle: pc_en = if_id_en = id_ex_en = ex_mem_en = 0, mem_wb_bubble = 1.
  - Next state MEM_WAIT; counter := 1.
- MEM_WAIT: the same freeze is held and dmem_req stays asserted.
  - On dmem_ack: freeze releases in that cycle (RUN decode applies); next state RUN.
  - Otherwise counter increments.
  - If TIMEOUT != 0 and counter == TIMEOUT without ack: next state ERR.
- ERR: full freeze; mem_wb_bubble = 1; dmem_req = 0; dmem_err = 1. Leaves only on reset.
- Taken control transfer: take = (branch_ex_mem & z_flag_ex_mem) | (pc_sel_ex_mem != 0).
  - If no memory stall is active: redirect = 1, and if_id_flush = id_ex_flush = ex_mem_flush = 1, squashing the three younger instructions.
  - Single cycle; the FSM stays in RUN.
- Load-use: memread_id_ex & (rd_id_ex != 0) & ((use_rs1_if_id & rd_id_ex == rs1_if_id) | (use_rs2_if_id & rd_id_ex == rs2_if_id)).
  - Response: pc_en = if_id_en = 0, id_ex_flush = 1. Exactly one bubble.
- Priority: memory stall/ERR > taken transfer > load-use.
  - Transfer during a stall is deferred. EX/MEM is frozen, so `take` is re-evaluated on the ack cycle.
  - Transfer together with load-use: flush wins; no stall.
- Reset mid-MEM_WAIT: immediate return to RUN; counter cleared; dmem_err cleared.
- Counter width: $clog2(TIMEOUT+1), minimum 1. The counter saturates and never wraps.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds three output ports of width CNT_W, each reset to 0 and wrapping modulo 2^CNT_W.
  - perf_stall_lu: counts load-use stall cycles.
  - perf_flush: counts taken-transfer flush events.
  - perf_mem_wait: counts frozen cycles, including ERR.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - the state typedef (RUN = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2);
  - the PC_SEL_SEQ = 2'd0 constant;
  - the REG_X0 = 5'd0 constant.
- One natural sub-module, load_use_detect: the purely combinational hazard compare, reused by the forwarding unit.

Test Plan:
- Load-use: memread_id_ex = 1, rd_id_ex = 5, rs2_if_id = 5, use_rs2 = 1 → exactly one cycle of pc_en = 0, if_id_en = 0, id_ex_flush = 1, then normal flow. With rd_id_ex = 0 → no stall.
- Branch: branch_ex_mem = 1, z_flag_ex_mem = 1 → one cycle of redirect = 1 and all three flushes = 1. Repeat with z_flag_ex_mem = 0 → no flush. Repeat with pc_sel_ex_mem = 2'b10 → flush.
- Memory wait: memread_ex_mem = 1, dmem_ack delayed 3 cycles → 3 frozen cycles with mem_wb_bubble = 1; release on the ack cycle; FSM returns to RUN.
- Simultaneous events: taken branch and load-use in the same cycle → flush only. Taken branch during MEM_WAIT → redirect asserted only on the ack cycle.
- Timeout: TIMEOUT = 4, no ack → ERR after 4 wait cycles; dmem_err = 1 and dmem_req = 0; asserting reset clears to RUN.
- Performance counters (HAZARD_PERF_EN only): 2 load-use stalls, 1 flush, 3 wait cycles → counters read 2, 1, 3.
